// File: rtl/fb_write_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_addr_gen_if
// Brief    : Frame-buffer write port (valid/ready, address + RGB565 data).
// Revision : 1.0
// ============================================================================
interface fb_write_addr_gen_if #(
    parameter int ADDR_W = 17
) ();
    logic              o_wr_valid;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [15:0]       o_wr_data;
    logic              i_wr_ready;

    modport master (
        output o_wr_valid,
        output o_wr_addr,
        output o_wr_data,
        input  i_wr_ready
    );

    modport slave (
        input  o_wr_valid,
        input  o_wr_addr,
        input  o_wr_data,
        output i_wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/fb_write_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_addr_gen
// Brief    : Walks an address-window cursor per pixel and queues linear
//            frame-buffer writes in a FWFT FIFO.
// Revision : 1.0
// ============================================================================
module fb_write_addr_gen #(
    parameter int H_RES      = 480,
    parameter int V_RES      = 272,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = 5
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    input  wire logic [15:0] i_pixel_data,
    input  wire logic        i_pixel_en_pls,
    input  wire logic [7:0]  i_inst_data,
    input  wire logic        i_inst_en_pls,
    input  wire logic [31:0] i_col_addr,
    input  wire logic [31:0] i_row_addr,
    fb_write_addr_gen_if.master wr_if,
    output logic [LVL_W-1:0] o_fifo_level,
    output logic             o_frame_done_pls,
    output logic             o_ovf,
    output logic             o_clip
);
    localparam int         PTR_W   = LVL_W - 1;
    localparam logic [7:0] C_RAMWR = 8'h2C;

    logic        w_ramwr, w_pix, w_x_last, w_y_last;
    logic [15:0] w_xs, w_xe, w_ys, w_ye;
    logic [15:0] xs_q, xe_q, ys_q, ye_q, cx_q, cy_q, cx_d, cy_d;
    logic        frame_done_q, ovf_q, clip_q;

    logic              s1_vld_q, s1_clip_q;
    logic [15:0]       s1_x_q, s1_y_q, s1_data_q;
    logic              s2_vld_q, s2_clip_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic [15:0]       s2_data_q;

    logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];
    logic [15:0]       mem_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [LVL_W-1:0]  cnt_q;
    logic              w_valid, w_full, w_pop, w_push_req, w_push, w_drop;

    // RAMWR has priority: a coincident pixel is discarded.
    assign w_ramwr  = i_inst_en_pls && (i_inst_data == C_RAMWR);
    assign w_pix    = i_pixel_en_pls && !w_ramwr;
    assign w_xs     = i_col_addr[31:16];
    assign w_xe     = (i_col_addr[15:0] < w_xs) ? w_xs : i_col_addr[15:0];
    assign w_ys     = i_row_addr[31:16];
    assign w_ye     = (i_row_addr[15:0] < w_ys) ? w_ys : i_row_addr[15:0];
    assign w_x_last = (cx_q == xe_q);
    assign w_y_last = (cy_q == ye_q);

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (w_ramwr) begin
            cx_d = w_xs;
            cy_d = w_ys;
        end else if (w_pix) begin
            if (!w_x_last) begin
                cx_d = cx_q + 16'd1;
            end else begin
                cx_d = xs_q;
                cy_d = w_y_last ? ys_q : (cy_q + 16'd1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            xs_q         <= '0;
            xe_q         <= 16'(H_RES - 1);
            ys_q         <= '0;
            ye_q         <= 16'(V_RES - 1);
            cx_q         <= '0;
            cy_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if (w_ramwr) begin
                xs_q <= w_xs;
                xe_q <= w_xe;
                ys_q <= w_ys;
                ye_q <= w_ye;
            end
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            frame_done_q <= w_pix && w_x_last && w_y_last;
        end
    end

    // Two-stage pipeline: capture/clip, then constant-multiply address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_clip_q <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s1_data_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_clip_q <= 1'b0;
            s2_addr_q <= '0;
            s2_data_q <= '0;
        end else begin
            s1_vld_q <= w_pix;
            if (w_pix) begin
                s1_x_q    <= cx_q;
                s1_y_q    <= cy_q;
                s1_data_q <= i_pixel_data;
                s1_clip_q <= (cx_q >= 16'(H_RES)) || (cy_q >= 16'(V_RES));
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_addr_q <= ADDR_W'(32'(s1_y_q) * 32'(H_RES) + 32'(s1_x_q));
                s2_data_q <= s1_data_q;
                s2_clip_q <= s1_clip_q;
            end
        end
    end

    assign w_valid    = (cnt_q != '0);
    assign w_full     = (cnt_q == LVL_W'(FIFO_DEPTH));
    assign w_pop      = w_valid && wr_if.i_wr_ready;
    assign w_push_req = s2_vld_q && !s2_clip_q;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            clip_q <= 1'b0;
        end else begin
            if (w_push) wptr_q <= wptr_q + PTR_W'(1);
            if (w_pop)  rptr_q <= rptr_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + LVL_W'(1);
                2'b01:   cnt_q <= cnt_q - LVL_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (w_ramwr)                    ovf_q  <= 1'b0;
            else if (w_drop)                ovf_q  <= 1'b1;
            if (w_ramwr)                    clip_q <= 1'b0;
            else if (s2_vld_q && s2_clip_q) clip_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mem_addr_q[wptr_q] <= s2_addr_q;
            mem_data_q[wptr_q] <= s2_data_q;
        end
    end

    assign wr_if.o_wr_valid = w_valid;
    assign wr_if.o_wr_addr  = w_valid ? mem_addr_q[rptr_q] : '0;
    assign wr_if.o_wr_data  = w_valid ? mem_data_q[rptr_q] : '0;
    assign o_fifo_level     = cnt_q;
    assign o_frame_done_pls = frame_done_q;
    assign o_ovf            = ovf_q;
    assign o_clip           = clip_q;
endmodule
`default_nettype wire

// File: tb/tb_fb_write_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_write_addr_gen
// Brief    : Directed, scoreboard-based bench for fb_write_addr_gen.
// Revision : 1.0
// ============================================================================
module tb_fb_write_addr_gen;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [15:0] i_pixel_data = '0;
    logic        i_pixel_en_pls = 1'b0;
    logic [7:0]  i_inst_data = '0;
    logic        i_inst_en_pls = 1'b0;
    logic [31:0] i_col_addr = '0;
    logic [31:0] i_row_addr = '0;
    logic [4:0]  o_fifo_level;
    logic        o_frame_done_pls, o_ovf, o_clip;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb_q[$];

    fb_write_addr_gen_if #(.ADDR_W(17)) wr_if ();

    fb_write_addr_gen dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_pixel_data     (i_pixel_data),
        .i_pixel_en_pls   (i_pixel_en_pls),
        .i_inst_data      (i_inst_data),
        .i_inst_en_pls    (i_inst_en_pls),
        .i_col_addr       (i_col_addr),
        .i_row_addr       (i_row_addr),
        .wr_if            (wr_if),
        .o_fifo_level     (o_fifo_level),
        .o_frame_done_pls (o_frame_done_pls),
        .o_ovf            (o_ovf),
        .o_clip           (o_clip)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake is stable at the falling edge and completes at the next rising edge.
    always @(negedge i_clk) begin
        if (i_rst_n && wr_if.o_wr_valid && wr_if.i_wr_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write observed=%0h expected=none",
                       {wr_if.o_wr_addr, wr_if.o_wr_data});
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                chk("wr_addr", 32'(wr_if.o_wr_addr), 32'(e[32:16]));
                chk("wr_data", 32'(wr_if.o_wr_data), 32'(e[15:0]));
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ramwr(input logic [31:0] col, input logic [31:0] row, input logic [7:0] cmd);
        i_col_addr    = col;
        i_row_addr    = row;
        i_inst_data   = cmd;
        i_inst_en_pls = 1'b1;
        tick();
        i_inst_en_pls = 1'b0;
        tick();
    endtask

    task automatic pix(input logic [15:0] d, input bit push, input logic [16:0] a, input bit fd);
        if (push) sb_q.push_back({a, d});
        i_pixel_data   = d;
        i_pixel_en_pls = 1'b1;
        tick();
        i_pixel_en_pls = 1'b0;
        chk("frame_done", 32'(o_frame_done_pls), 32'(fd));
        repeat (15) tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
        tick();
        chk("drain_queue_left", 32'(sb_q.size()), 32'd0);
        chk("drain_level", 32'(o_fifo_level), 32'd0);
    endtask

    initial begin
        wr_if.i_wr_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(wr_if.o_wr_valid), 32'd0);
        chk("rst_level", 32'(o_fifo_level), 32'd0);
        chk("rst_flags", 32'({o_frame_done_pls, o_ovf, o_clip}), 32'd0);
        chk("rst_addr_data", 32'({wr_if.o_wr_addr, wr_if.o_wr_data}), 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        tick();

        // Default window, pipeline latency
        sb_q.push_back({17'd0, 16'h1234});
        i_pixel_data   = 16'h1234;
        i_pixel_en_pls = 1'b1;
        tick();
        i_pixel_en_pls = 1'b0;
        chk("lat_e0_valid", 32'(wr_if.o_wr_valid), 32'd0);
        tick();
        chk("lat_e1_valid", 32'(wr_if.o_wr_valid), 32'd0);
        tick();
        chk("lat_e2_valid", 32'(wr_if.o_wr_valid), 32'd1);
        chk("lat_level", 32'(o_fifo_level), 32'd1);
        wr_if.i_wr_ready = 1'b1;
        drain();

        // Window walk 10..12 x 5..6
        ramwr(32'h000A_000C, 32'h0005_0006, 8'h2C);
        pix(16'h0001, 1, 17'd2410, 0);
        pix(16'h0002, 1, 17'd2411, 0);
        pix(16'h0003, 1, 17'd2412, 0);
        pix(16'h0004, 1, 17'd2890, 0);
        pix(16'h0005, 1, 17'd2891, 0);
        pix(16'h0006, 1, 17'd2892, 1);
        pix(16'h0007, 1, 17'd2410, 0);
        drain();

        // Overflow: 17 pixels into a stalled FIFO
        wr_if.i_wr_ready = 1'b0;
        ramwr(32'h0000_0063, 32'h0000_0000, 8'h2C);
        for (int i = 0; i < 16; i++) pix(16'hA000 + 16'(i), 1, 17'(i), 0);
        chk("ovf_before", 32'(o_ovf), 32'd0);
        chk("ovf_full_level", 32'(o_fifo_level), 32'd16);
        pix(16'hA010, 0, 17'd0, 0);
        chk("ovf_set", 32'(o_ovf), 32'd1);
        chk("ovf_level", 32'(o_fifo_level), 32'd16);
        wr_if.i_wr_ready = 1'b1;
        drain();
        chk("ovf_sticky", 32'(o_ovf), 32'd1);
        ramwr(32'h0000_0063, 32'h0000_0000, 8'h2C);
        chk("ovf_cleared", 32'(o_ovf), 32'd0);

        // Clip at the right edge
        wr_if.i_wr_ready = 1'b0;
        ramwr(32'h01DE_01E1, 32'h0000_0000, 8'h2C);
        pix(16'hC000, 1, 17'd478, 0);
        pix(16'hC001, 1, 17'd479, 0);
        chk("clip_before", 32'(o_clip), 32'd0);
        pix(16'hC002, 0, 17'd0, 0);
        pix(16'hC003, 0, 17'd0, 1);
        chk("clip_set", 32'(o_clip), 32'd1);
        chk("clip_level", 32'(o_fifo_level), 32'd2);
        wr_if.i_wr_ready = 1'b1;
        drain();

        // Degenerate column window, collision, ignored command
        ramwr(32'h0014_000A, 32'h0003_0004, 8'h2C);
        chk("clip_cleared", 32'(o_clip), 32'd0);
        pix(16'hD000, 1, 17'd1460, 0);
        pix(16'hD001, 1, 17'd1940, 1);
        pix(16'hD002, 1, 17'd1460, 0);
        i_pixel_data   = 16'hDEAD;
        i_pixel_en_pls = 1'b1;
        i_inst_data    = 8'h2C;
        i_inst_en_pls  = 1'b1;
        tick();
        i_pixel_en_pls = 1'b0;
        i_inst_en_pls  = 1'b0;
        repeat (5) tick();
        chk("collide_level", 32'(o_fifo_level), 32'd0);
        pix(16'hD003, 1, 17'd1460, 0);
        ramwr(32'h0000_0000, 32'h0000_0000, 8'h2A);
        pix(16'hD004, 1, 17'd1940, 1);
        drain();

        // Asynchronous reset with entries queued
        wr_if.i_wr_ready = 1'b0;
        pix(16'hE000, 1, 17'd1460, 0);
        pix(16'hE001, 1, 17'd1940, 1);
        pix(16'hE002, 1, 17'd1460, 0);
        pix(16'hE003, 1, 17'd1940, 1);
        pix(16'hE004, 1, 17'd1460, 0);
        chk("pre_rst_level", 32'(o_fifo_level), 32'd5);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(wr_if.o_wr_valid), 32'd0);
        chk("arst_level", 32'(o_fifo_level), 32'd0);
        sb_q.delete();
        tick();
        i_rst_n = 1'b1;
        wr_if.i_wr_ready = 1'b1;
        tick();
        pix(16'hBEEF, 1, 17'd0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/fb_write_addr_gen.md
Name: fb_write_addr_gen

Overview:
Downstream stage of the SPI slave receiver. It consumes pixel, instruction and window-address outputs, walks a write cursor through the ST7735R-style address window (XS..XE, YS..YE), and converts each pixel into a linear frame-buffer write (address + RGB565 data). Writes are queued in a small FIFO toward the frame-buffer memory port with a valid/ready handshake. Runs on the FPGA internal clock.

Parameters:
H_RES, 480, visible columns; linear address = y*H_RES + x
V_RES, 272, visible rows
ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
FIFO_DEPTH, 16, write FIFO entries; power of two
LVL_W, 5, width of o_fifo_level; equals log2(FIFO_DEPTH)+1

Ports:
i_clk  in  1  FPGA internal clock
i_rst_n  in  1  asynchronous active-low reset
i_pixel_data  in  16  RGB565 pixel from SPI slave
i_pixel_en_pls  in  1  1-cycle pulse: i_pixel_data valid
i_inst_data  in  8  last command byte
i_inst_en_pls  in  1  1-cycle pulse: new command byte
i_col_addr  in  32  XS[31:16], XE[15:0]
i_row_addr  in  32  YS[31:16], YE[15:0]
o_wr_valid  out  1  FIFO head valid
o_wr_addr  out  ADDR_W  write address at FIFO head
o_wr_data  out  16  write data at FIFO head
i_wr_ready  in  1  memory accepts head when o_wr_valid & i_wr_ready
o_fifo_level  out  LVL_W  entries in FIFO
o_frame_done_pls  out  1  pulse: last pixel of window accepted
o_ovf  out  1  sticky: pixel dropped, FIFO full
o_clip  out  1  sticky: pixel dropped, outside H_RES/V_RES

Behaviour:
- Reset (async, i_rst_n low): all outputs 0; FIFO empty; window = 0..H_RES-1 x 0..V_RES-1; cursor (0,0). Reset mid-operation discards FIFO contents and the pipeline immediately.
- RAMWR: i_inst_en_pls with i_inst_data==8'h2C snapshots i_col_addr/i_row_addr into window registers, sets cursor x=XS, y=YS, clears o_ovf and o_clip. Other commands are ignored. The window is held until the next RAMWR; later changes on i_col_addr/i_row_addr have no effect.
- Degenerate window: if XS>XE, XE is treated as XS (one column); the same rule applies for YS>YE.
- Pixel pulse while the window is idle after reset uses the default window.
- RAMWR and i_pixel_en_pls in the same cycle: RAMWR wins and the pixel is discarded.
- Cursor advance per pixel pulse: if x!=XE then x++; else x=XS and (y==YE ? y=YS : y++). When x==XE and y==YE, the pixel raises o_frame_done_pls for 1 cycle, 1 cycle after the pulse, and the cursor wraps to (XS,YS).
- Pipeline: stage 1 registers x, y, data and a clip flag (x>=H_RES or y>=V_RES). Stage 2 registers addr = y*H_RES + x, truncated to ADDR_W, using a constant multiply. The FIFO push occurs at the edge after stage 2. A pulse sampled at edge E0 makes o_wr_valid visible after E2 when the FIFO was empty.
- Clipped pixels are never pushed and set o_clip; the cursor still advances.
- FIFO: FWFT; o_wr_addr/o_wr_data show the head whenever o_wr_valid=1. Pop happens on o_wr_valid & i_wr_ready. Push and pop in the same cycle leave the level unchanged (valid when full, because pop frees the slot).
- Full and no pop on push: the pixel is dropped, o_ovf set, FIFO unchanged. Empty: o_wr_valid=0; i_wr_ready is ignored.
- Upstream guarantees ≥16 clocks between pixel pulses, so the pipeline has no internal backpressure.
- o_fifo_level ranges 0..FIFO_DEPTH, updated the cycle after each push/pop.

Test Plan:
- Reset check: all outputs 0 after reset; pixel 16'h1234 with no prior RAMWR -> entry addr 0, data 16'h1234, o_wr_valid visible 3 edges after the pulse.
- Window walk: col=0x000A000C, row=0x00050006, RAMWR, 7 pixels, i_wr_ready=1 -> addrs 2410,2411,2412,2890,2891,2892,2410; o_frame_done_pls after 6th pixel only.
- Overflow: i_wr_ready=0, 17 pixels -> level 16, o_ovf=1 after 17th; then ready=1 drains exactly the first 16 in order; next RAMWR clears o_ovf.
- Clip: col=0x01DE01E1 (478..481), row=0/0, 4 pixels -> addrs 478,479 pushed only; o_clip=1; level 2.
- Degenerate/collision: col XS=20, XE=10, row 3..4 -> addrs 1460,1940,1460; pixel pulse coincident with RAMWR -> no push, cursor at (XS,YS).
- Async reset asserted with 5 entries queued -> o_wr_valid=0, level 0 immediately; post-reset pixel goes to addr 0.
